pipeline_stall_ctrl: RTL

Pipeline interlock controller for the 5-stage ARM core. It consumes the ID-stage `hazard_detected` flag, the EXE-stage branch-taken flag and the SRAM handshake. It drives the per-stage freeze, flush and bubble controls of the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers. It also keeps saturating performance counters and sticky error flags. It sits beside the hazard detection unit and closes the loop from hazard indication to pipeline response.

---
 rtl/pipeline_stall_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Interlock controller: maps hazard/branch/SRAM-wait inputs to per-stage freeze, flush and bubble controls.
// Controls are combinational (Mealy). Counters and sticky flags update one cycle after the cause.
module pipeline_stall_ctrl #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  input  logic             perf_clear,
  output logic             pc_freeze,
  output logic             if_id_freeze,
  output logic             if_id_flush,
  output logic             id_ex_freeze,
  output logic             id_ex_bubble,
  output logic             ex_mem_freeze,
  output logic             mem_wb_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic [CNT_W-1:0] mem_wait_count,
  output logic             hazard_error,
  output logic             mem_timeout
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [16:0]      TIMEOUT_LIM = 17'(MEM_TIMEOUT);

  state_t      cur_state;
  state_t      nxt_state;
  logic        sel_mem;
  logic        sel_br;
  logic        sel_hz;
  logic [15:0] wait_cnt;
  logic [16:0] wait_inc;
  logic        in_wait;
  logic        timeout_hit;
  logic        repeat_hazard;

  assign state = cur_state;

  // One class per cycle: memory wait beats branch beats hazard.
  always_comb begin
    sel_mem = mem_access & ~mem_ready;
    sel_br  = ~sel_mem & branch_taken;
    sel_hz  = ~sel_mem & ~branch_taken & hazard_detected;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= RUN;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state     = RUN;
    pc_freeze     = 1'b0;
    if_id_freeze  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_freeze  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_freeze = 1'b0;
    mem_wb_bubble = 1'b0;
    if (sel_mem) begin
      nxt_state     = MEM_WAIT;
      pc_freeze     = 1'b1;
      if_id_freeze  = 1'b1;
      id_ex_freeze  = 1'b1;
      ex_mem_freeze = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (sel_br) begin
      nxt_state    = RUN;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (sel_hz) begin
      nxt_state    = LOAD_STALL;
      pc_freeze    = 1'b1;
      if_id_freeze = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // wait_cnt only advances once already in MEM_WAIT, so the flag needs MEM_TIMEOUT+1 wait cycles.
  assign in_wait       = (cur_state == MEM_WAIT) & sel_mem;
  assign wait_inc      = {1'b0, wait_cnt} + 17'd1;
  assign timeout_hit   = in_wait & (wait_inc >= TIMEOUT_LIM);
  assign repeat_hazard = (cur_state == LOAD_STALL) & sel_hz;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 16'd0;
    end else if (in_wait) begin
      if (wait_cnt != 16'hFFFF) wait_cnt <= wait_inc[15:0];
    end else begin
      wait_cnt <= 16'd0;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count    <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
      hazard_error   <= 1'b0;
      mem_timeout    <= 1'b0;
    end else if (perf_clear) begin
      stall_count    <= '0;
      flush_count    <= '0;
      mem_wait_count <= '0;
      hazard_error   <= 1'b0;
      mem_timeout    <= 1'b0;
    end else begin
      if (sel_hz)        stall_count    <= sat_inc(stall_count);
      if (sel_br)        flush_count    <= sat_inc(flush_count);
      if (sel_mem)       mem_wait_count <= sat_inc(mem_wait_count);
      if (repeat_hazard) hazard_error   <= 1'b1;
      if (timeout_hit)   mem_timeout    <= 1'b1;
    end
  end

endmodule
